// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: opcodes, instruction field positions and FSM states shared by the sequencer
package alu_sequencer_pkg;

    localparam logic [3:0] OP_LDI  = 4'd0;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam int OP_LSB   = 12;
    localparam int RD_LSB   = 9;
    localparam int RS_LSB   = 6;
    localparam int RT_LSB   = 3;
    localparam int HIWE_BIT = 2;
    localparam int IMM_W    = 9;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HALT
    } state_t;

endpackage

// File: rtl/alu_sequencer_seq_regfile.sv
// seq_regfile: register file with two operand read ports, a debug port and one write port; r0 reads 0
module seq_regfile
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       ra,
    input  logic [2:0]       rb,
    input  logic [2:0]       rdbg,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] qdbg,
    input  logic             we,
    input  logic [2:0]       wa,
    input  logic [WIDTH-1:0] wd
);

    logic [WIDTH-1:0] mem [NREGS];

    // storage update; r0 is never written so it stays at its reset value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && wa != 3'd0) begin
            mem[wa] <= wd;
        end
    end

    assign qa   = (ra == 3'd0) ? '0 : mem[ra];
    assign qb   = (rb == 3'd0) ? '0 : mem[rb];
    assign qdbg = (rdbg == 3'd0) ? '0 : mem[rdbg];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/writeback stage feeding the ALU from a register file, one instruction per two cycles
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [2:0]       alu_flags,
    input  logic [WIDTH-1:0] alu_hi,
    output logic             wb_valid,
    output logic [2:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] hi_q,
    output logic [2:0]       flags_q,
    output logic             halted,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    import alu_sequencer_pkg::*;

    state_t state, state_n;

    logic [3:0]       f_op;
    logic [2:0]       f_rd, f_rs, f_rt;
    logic             f_hi_we;
    logic [IMM_W-1:0] f_imm;
    logic             unused_rsvd;

    logic             is_ldi_q, hi_we_q;
    logic [2:0]       rd_q;
    logic [IMM_W-1:0] imm_q;

    logic [WIDTH-1:0] rs_data, rt_data, wr_data;
    logic             accept, wr_en;

    assign f_op        = instr[OP_LSB +: 4];
    assign f_rd        = instr[RD_LSB +: 3];
    assign f_rs        = instr[RS_LSB +: 3];
    assign f_rt        = instr[RT_LSB +: 3];
    assign f_hi_we     = instr[HIWE_BIT];
    assign f_imm       = instr[IMM_W-1:0];
    assign unused_rsvd = ^instr[HIWE_BIT-1:0];

    seq_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
        .clk  (clk),
        .rst  (rst),
        .ra   (f_rs),
        .rb   (f_rt),
        .rdbg (dbg_addr),
        .qa   (rs_data),
        .qb   (rt_data),
        .qdbg (dbg_data),
        .we   (wr_en),
        .wa   (rd_q),
        .wd   (wr_data)
    );

    // next state: accept only in IDLE, EXEC lasts one cycle, HALT holds until reset
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                accept = instr_valid;
                if (instr_valid) state_n = (f_op == OP_HALT) ? HALT : EXEC;
            end
            EXEC:    state_n = IDLE;
            default: state_n = HALT;
        endcase
    end

    assign instr_ready = (state == IDLE);
    assign halted      = (state == HALT);
    assign wr_en       = (state == EXEC);
    assign wr_data     = is_ldi_q ? WIDTH'(imm_q) : alu_out;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // decode and operand capture at accept; ALU inputs then stay stable through EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_ldi_q <= 1'b0;
            hi_we_q  <= 1'b0;
            rd_q     <= '0;
            imm_q    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
        end else if (accept) begin
            is_ldi_q <= (f_op == OP_LDI);
            hi_we_q  <= f_hi_we;
            rd_q     <= f_rd;
            imm_q    <= f_imm;
            alu_a    <= rs_data;
            alu_b    <= rt_data;
            alu_op   <= (f_op == OP_LDI || f_op == OP_HALT) ? 4'd0 : f_op;
        end
    end

    // writeback report and status capture at the end of EXEC; LDI leaves flags and HI alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            flags_q  <= '0;
            hi_q     <= '0;
        end else begin
            wb_valid <= wr_en;
            if (wr_en) begin
                wb_rd   <= rd_q;
                wb_data <= wr_data;
                if (!is_ldi_q) begin
                    flags_q <= alu_flags;
                    if (hi_we_q) hi_q <= alu_hi;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized scoreboard bench with a stand-in ALU and an architectural register model
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic [15:0] alu_a, alu_b, alu_out, alu_hi, wb_data, hi_q, dbg_data;
    logic [3:0]  alu_op;
    logic [2:0]  alu_flags, wb_rd, flags_q, dbg_addr = '0;
    logic        wb_valid, halted;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
        logic [2:0]  fl;
        logic [15:0] hi;
    } wb_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } ex_t;

    wb_t wq[$];
    ex_t xq[$];
    wb_t e;
    ex_t x;

    logic [15:0] m [8];
    logic [15:0] mh;
    logic [2:0]  mf;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_flags(alu_flags),
        .alu_hi(alu_hi), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .hi_q(hi_q),
        .flags_q(flags_q), .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] f_out(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        return (a ^ {4{op}}) + {b[14:0], b[15]} + 16'(op) * 16'd257;
    endfunction

    function automatic logic [15:0] f_hi(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        return (a - b) ^ {op, 12'h5A5};
    endfunction

    function automatic logic [2:0] f_flags(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        return {^f_out(a, b, op), a < b, op[0] ^ b[0]};
    endfunction

    always_comb begin
        alu_out   = f_out(alu_a, alu_b, alu_op);
        alu_hi    = f_hi(alu_a, alu_b, alu_op);
        alu_flags = f_flags(alu_a, alu_b, alu_op);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic model(input logic [15:0] w);
        logic [3:0]  op = w[15:12];
        logic [2:0]  rd = w[11:9];
        logic [2:0]  rs = w[8:6];
        logic [2:0]  rt = w[5:3];
        logic [15:0] a  = m[rs];
        logic [15:0] b  = m[rt];
        logic [15:0] d;
        if (op == 4'd15) return;
        xq.push_back('{a, b, (op == 4'd0) ? 4'd0 : op});
        if (op == 4'd0) begin
            d = {7'd0, w[8:0]};
        end else begin
            d  = f_out(a, b, op);
            mf = f_flags(a, b, op);
            if (w[2]) mh = f_hi(a, b, op);
        end
        if (rd != 3'd0) m[rd] = d;
        wq.push_back('{rd, d, mf, mh});
    endtask

    task automatic issue(input logic [15:0] w);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 0, 1);
        instr       = w;
        instr_valid = 1'b1;
        model(w);
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (wq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", wq.size(), 0);
    endtask

    task automatic dbg_sweep();
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a);
            #1 chk("dbg_data", dbg_data, m[a]);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, instr_ready, 1);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_rd"}, wb_rd, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_hi"}, hi_q, 0);
        chk({tag, "_flags"}, flags_q, 0);
        chk({tag, "_halted"}, halted, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid) begin
                if (wq.size() == 0) begin
                    chk("wb_unexpected", 1, 0);
                end else begin
                    e = wq.pop_front();
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_data", wb_data, e.data);
                    chk("flags_q", flags_q, e.fl);
                    chk("hi_q", hi_q, e.hi);
                end
            end
            if (!instr_ready && !halted) begin
                if (xq.size() == 0) begin
                    chk("exec_unexpected", 1, 0);
                end else begin
                    x = xq.pop_front();
                    chk("alu_a", alu_a, x.a);
                    chk("alu_b", alu_b, x.b);
                    chk("alu_op", alu_op, x.op);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) m[i] = '0;
        mh = '0;
        mf = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        @(negedge clk);
        instr       = {4'd1, 3'd1, 3'd0, 3'd0, 1'b1, 2'b00};
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_wb_valid", wb_valid, 0);
        end
        chk_zero("abort");
        dbg_sweep();

        issue({4'd0, 3'd1, 9'd3});
        issue({4'd0, 3'd2, 9'd511});
        drain();
        dbg_sweep();

        for (int op = 1; op <= 9; op++) issue({4'(op), 3'd3, 3'd1, 3'd2, 1'b1, 2'b00});
        issue({4'd3, 3'd4, 3'd3, 3'd1, 1'b0, 2'b00});
        issue({4'd0, 3'd0, 9'd5});
        drain();
        dbg_sweep();

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue({4'($urandom_range(0, 14)), 12'($urandom)});
        end
        drain();
        dbg_sweep();

        issue(16'hF000);
        instr       = 16'h1234;
        instr_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("halt_halted", halted, 1);
            chk("halt_ready", instr_ready, 0);
        end
        chk("halt_no_wb", wq.size() + xq.size(), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_halt_halted", halted, 0);
        chk("post_halt_ready", instr_ready, 1);
        chk("post_halt_hi", hi_q, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
